// File: rtl/seqdet_param.sv
// seqdet_param: programmable serial pattern detector with overlap control and saturating match counter
module seqdet_param #(
    parameter int               PAT_W       = 4,
    parameter logic [PAT_W-1:0] DEFAULT_PAT = 4'b1101,
    parameter int               CNT_W       = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             din_valid,
    input  logic             din,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pattern,
    input  logic             overlap,
    input  logic             cnt_clr,
    output logic             dout,
    output logic [CNT_W-1:0] match_cnt,
    output logic             armed
);
    localparam int               FW   = $clog2(PAT_W + 1);
    localparam logic [FW-1:0]    FULL = FW'(PAT_W);
    localparam logic [CNT_W-1:0] CMAX = '1;

    logic [PAT_W-1:0] pat_reg, pat_n, hist, hist_n, hist_sh;
    logic [FW-1:0]    fill, fill_n, fill_inc;
    logic [CNT_W-1:0] cnt_n;
    logic             accept, hit;

    // next-state: shift accepted bits, track fill level, detect match, update counter
    always_comb begin
        hist_sh  = {hist[PAT_W-2:0], din};
        fill_inc = (fill == FULL) ? FULL : fill + 1'b1;
        accept   = din_valid && !pat_load;
        hit      = accept && (fill_inc == FULL) && (hist_sh == pat_reg);
        pat_n    = pat_load ? pattern : pat_reg;
        hist_n   = pat_load ? '0 : (accept ? hist_sh : hist);
        fill_n   = pat_load ? '0 : (accept ? ((hit && !overlap) ? '0 : fill_inc) : fill);
        cnt_n    = cnt_clr ? '0 : ((hit && match_cnt != CMAX) ? match_cnt + 1'b1 : match_cnt);
    end

    // state and registered outputs; active-low clr wins over everything
    always_ff @(posedge clk) begin
        if (!clr) begin
            pat_reg   <= DEFAULT_PAT;
            hist      <= '0;
            fill      <= '0;
            dout      <= 1'b0;
            match_cnt <= '0;
            armed     <= 1'b0;
        end else begin
            pat_reg   <= pat_n;
            hist      <= hist_n;
            fill      <= fill_n;
            dout      <= hit;
            match_cnt <= cnt_n;
            armed     <= (fill_n == FULL);
        end
    end
endmodule
